// File: rtl/encoder_pkg.sv
// Shared types and helpers for the quadrature encoder emulator: quadrature state,
// step direction constants and the per-direction next-state functions.
package encoder_pkg;

  typedef enum logic [1:0] {
    QuadAb00 = 2'b00,
    QuadAb01 = 2'b01,
    QuadAb11 = 2'b11,
    QuadAb10 = 2'b10
  } quad_e;

  typedef enum logic {
    StIdle,
    StRun
  } enc_state_e;

  localparam int unsigned MIN_PERIOD_DEFAULT = 2;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

  // Forward walk on {A,B}: 00 -> 01 -> 11 -> 10 -> 00
  function automatic quad_e quad_fwd(quad_e s);
    quad_e n;
    case (s)
      QuadAb00: n = QuadAb01;
      QuadAb01: n = QuadAb11;
      QuadAb11: n = QuadAb10;
      default:  n = QuadAb00;
    endcase
    return n;
  endfunction

  // Reverse walk on {A,B}: 00 -> 10 -> 11 -> 01 -> 00
  function automatic quad_e quad_rev(quad_e s);
    quad_e n;
    case (s)
      QuadAb00: n = QuadAb10;
      QuadAb10: n = QuadAb11;
      QuadAb11: n = QuadAb01;
      default:  n = QuadAb00;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/quad_step_timer.sv
// Loadable down-counter pacing quadrature steps; flags the step boundary (count 0)
// and whether the next count value hits the mid-point compare value.
module quad_step_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic [Width-1:0] mid_val_i,
  output logic             tick_o,
  output logic             mid_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - One;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick_o = (count_q == '0);
  // Compared against the next value so the caller can register the result in step.
  assign mid_o  = (count_d == mid_val_i);

endmodule

// File: rtl/quadrature_encoder_emulator.sv
// Quadrature A/B generator with a one-deep command holding register, signed position
// count, step strobe and optional single-cycle glitch on A for debounce testing.
module quadrature_encoder_emulator
  import encoder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MIN_PERIOD = MIN_PERIOD_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [DATA_WIDTH-1:0] cmd_period_i,
  input  logic                  cmd_dir_i,
  input  logic                  glitch_en_i,
  output logic                  encoder_a_o,
  output logic                  encoder_b_o,
  output logic [DATA_WIDTH-1:0] position_o,
  output logic                  step_strobe_o
);

  localparam logic [DATA_WIDTH-1:0] One       = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] MinP      = DATA_WIDTH'(MIN_PERIOD);
  localparam logic [DATA_WIDTH-1:0] GlitchMin = DATA_WIDTH'(4);

  logic                  hold_full_q;
  logic [DATA_WIDTH-1:0] hold_period_q;
  logic                  hold_dir_q;
  enc_state_e            state_q;
  logic [DATA_WIDTH-1:0] act_period_q;
  logic                  act_dir_q;
  quad_e                 quad_q;
  logic [DATA_WIDTH-1:0] position_q;
  logic                  strobe_q;
  logic                  glitch_q;

  logic                  accept, running, boundary, idle_take, run_take, hold_nonzero;
  logic                  tmr_load, tmr_en, tmr_tick, tmr_mid, glitch_d;
  logic [DATA_WIDTH-1:0] tmr_load_val, cmd_clamped, half_period, pos_next;
  quad_e                 quad_next;

  always_comb begin
    accept       = cmd_valid_i && !hold_full_q;
    cmd_clamped  = ((cmd_period_i != '0) && (cmd_period_i < MinP)) ? MinP : cmd_period_i;
    running      = (state_q == StRun);
    hold_nonzero = (hold_period_q != '0);
    boundary     = running && enable_i && tmr_tick;
    idle_take    = !running && enable_i && hold_full_q;
    run_take     = boundary && hold_full_q;
    half_period  = act_period_q >> 1;

    tmr_en   = running && enable_i;
    // While frozen in RUN the counter is held at a full period so re-enable restarts the step.
    tmr_load = (idle_take && hold_nonzero) || boundary || (running && !enable_i);
    tmr_load_val = ((idle_take || run_take) && hold_nonzero) ? hold_period_q - One
                                                              : act_period_q - One;

    glitch_d = running && enable_i && glitch_en_i && (act_period_q >= GlitchMin) &&
               tmr_mid && !tmr_tick;

    quad_next = (act_dir_q == DIR_REV) ? quad_rev(quad_q) : quad_fwd(quad_q);
    pos_next  = (act_dir_q == DIR_REV) ? position_q - One : position_q + One;
  end

  quad_step_timer #(
    .Width(DATA_WIDTH)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (tmr_en),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .mid_val_i  (half_period),
    .tick_o     (tmr_tick),
    .mid_o      (tmr_mid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_full_q   <= 1'b0;
      hold_period_q <= '0;
      hold_dir_q    <= DIR_FWD;
      state_q       <= StIdle;
      act_period_q  <= '0;
      act_dir_q     <= DIR_FWD;
      quad_q        <= QuadAb00;
      position_q    <= '0;
      strobe_q      <= 1'b0;
      glitch_q      <= 1'b0;
    end else begin
      strobe_q <= boundary;
      glitch_q <= glitch_d;

      if (idle_take || run_take) begin
        hold_full_q <= 1'b0;
      end else if (accept) begin
        hold_full_q   <= 1'b1;
        hold_period_q <= cmd_clamped;
        hold_dir_q    <= cmd_dir_i;
      end

      case (state_q)
        StIdle: begin
          if (idle_take && hold_nonzero) begin
            act_period_q <= hold_period_q;
            act_dir_q    <= hold_dir_q;
            state_q      <= StRun;
          end
        end
        default: begin
          if (boundary) begin
            quad_q     <= quad_next;
            position_q <= pos_next;
            // A pending command takes effect after this step, never on it.
            if (run_take) begin
              if (hold_nonzero) begin
                act_period_q <= hold_period_q;
                act_dir_q    <= hold_dir_q;
              end else begin
                act_period_q <= '0;
                state_q      <= StIdle;
              end
            end
          end
        end
      endcase
    end
  end

  assign cmd_ready_o   = !hold_full_q;
  assign encoder_a_o   = quad_q[1] ^ glitch_q;
  assign encoder_b_o   = quad_q[0];
  assign position_o    = position_q;
  assign step_strobe_o = strobe_q;

endmodule

// File: tb/tb_quadrature_encoder_emulator.sv
// Directed bench for quadrature_encoder_emulator: step timing, sequence, commands,
// clamping, stop, enable freeze, glitch injection and asynchronous reset.
module tb_quadrature_encoder_emulator;

  logic        clk_i, rst_ni, enable_i, cmd_valid_i, cmd_dir_i, glitch_en_i;
  logic [15:0] cmd_period_i;
  logic        cmd_ready_o, encoder_a_o, encoder_b_o, step_strobe_o;
  logic [15:0] position_o;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  quadrature_encoder_emulator #(
    .DATA_WIDTH(16),
    .MIN_PERIOD(2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_period_i  (cmd_period_i),
    .cmd_dir_i     (cmd_dir_i),
    .glitch_en_i   (glitch_en_i),
    .encoder_a_o   (encoder_a_o),
    .encoder_b_o   (encoder_b_o),
    .position_o    (position_o),
    .step_strobe_o (step_strobe_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [15:0] p, input logic d);
    cmd_valid_i  = 1'b1;
    cmd_period_i = p;
    cmd_dir_i    = d;
    tick_n(1);
    cmd_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({encoder_a_o, encoder_b_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ab: got %b expected 00", {encoder_a_o, encoder_b_o});
    end
    n_cmp++;
    if (position_o !== 16'd0) begin
      n_fail++; $display("FAIL reset_pos: got %0d expected 0", position_o);
    end
    n_cmp++;
    if (step_strobe_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_strobe: got %b expected 0", step_strobe_o);
    end
    n_cmp++;
    if (cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready_o);
    end
  endtask

  task automatic test_forward();
    logic [1:0] exp_ab [6];
    int rise0, rise1;
    exp_ab = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
    rise0 = 0;
    rise1 = 0;
    enable_i = 1'b1;
    send_cmd(16'd10, 1'b0);
    n_cmp++;
    if (cmd_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL fwd_ready_low: got %b expected 0", cmd_ready_o);
    end
    tick_n(10);
    n_cmp++;
    if ({encoder_a_o, encoder_b_o, step_strobe_o} !== 3'b000) begin
      n_fail++; $display("FAIL fwd_early: got %b expected 000",
                         {encoder_a_o, encoder_b_o, step_strobe_o});
    end
    tick_n(1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        tick_n(9);
        n_cmp++;
        if (step_strobe_o !== 1'b0) begin
          n_fail++; $display("FAIL fwd_gap%0d: got strobe %b expected 0", i, step_strobe_o);
        end
        tick_n(1);
      end
      n_cmp++;
      if ({encoder_a_o, encoder_b_o, step_strobe_o} !== {exp_ab[i], 1'b1}) begin
        n_fail++; $display("FAIL fwd_step%0d: got %b expected %b", i,
                           {encoder_a_o, encoder_b_o, step_strobe_o}, {exp_ab[i], 1'b1});
      end
      n_cmp++;
      if (position_o !== 16'(i + 1)) begin
        n_fail++; $display("FAIL fwd_pos%0d: got %0d expected %0d", i, position_o, i + 1);
      end
      if (i == 1) rise0 = cyc;
      if (i == 5) rise1 = cyc;
    end
    n_cmp++;
    if (rise1 - rise0 != 40) begin
      n_fail++; $display("FAIL fwd_a_period: got %0d expected 40", rise1 - rise0);
    end
  endtask

  task automatic test_dir_change();
    logic [1:0] exp_ab [4];
    exp_ab = '{2'b11, 2'b01, 2'b00, 2'b10};
    tick_n(3);
    send_cmd(16'd6, 1'b1);
    tick_n(5);
    n_cmp++;
    if (step_strobe_o !== 1'b0) begin
      n_fail++; $display("FAIL dir_early: got strobe %b expected 0", step_strobe_o);
    end
    tick_n(1);
    n_cmp++;
    if ({encoder_a_o, encoder_b_o, step_strobe_o, position_o} !== {3'b101, 16'd7}) begin
      n_fail++; $display("FAIL dir_complete: got ab/strobe %b pos %0d expected 101 pos 7",
                         {encoder_a_o, encoder_b_o, step_strobe_o}, position_o);
    end
    n_cmp++;
    if (cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL dir_ready: got %b expected 1", cmd_ready_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick_n(5);
      n_cmp++;
      if (step_strobe_o !== 1'b0) begin
        n_fail++; $display("FAIL rev_gap%0d: got strobe %b expected 0", i, step_strobe_o);
      end
      tick_n(1);
      n_cmp++;
      if ({encoder_a_o, encoder_b_o, step_strobe_o} !== {exp_ab[i], 1'b1} ||
          position_o !== 16'(6 - i)) begin
        n_fail++; $display("FAIL rev_step%0d: got ab/strobe %b pos %0d expected %b pos %0d", i,
                           {encoder_a_o, encoder_b_o, step_strobe_o}, position_o,
                           {exp_ab[i], 1'b1}, 6 - i);
      end
    end
  endtask

  task automatic test_clamp_stop();
    logic moved;
    send_cmd(16'd1, 1'b0);
    tick_n(4);
    n_cmp++;
    if (step_strobe_o !== 1'b0) begin
      n_fail++; $display("FAIL clamp_early: got strobe %b expected 0", step_strobe_o);
    end
    tick_n(1);
    n_cmp++;
    if ({encoder_a_o, encoder_b_o, cmd_ready_o} !== 3'b111 || position_o !== 16'd2) begin
      n_fail++; $display("FAIL clamp_take: got ab/ready %b pos %0d expected 111 pos 2",
                         {encoder_a_o, encoder_b_o, cmd_ready_o}, position_o);
    end
    tick_n(1);
    n_cmp++;
    if (step_strobe_o !== 1'b0) begin
      n_fail++; $display("FAIL clamp_gap: got strobe %b expected 0", step_strobe_o);
    end
    tick_n(1);
    n_cmp++;
    if ({encoder_a_o, encoder_b_o, step_strobe_o} !== 3'b101 || position_o !== 16'd3) begin
      n_fail++; $display("FAIL clamp_step1: got %b pos %0d expected 101 pos 3",
                         {encoder_a_o, encoder_b_o, step_strobe_o}, position_o);
    end
    tick_n(2);
    n_cmp++;
    if ({encoder_a_o, encoder_b_o, step_strobe_o} !== 3'b001 || position_o !== 16'd4) begin
      n_fail++; $display("FAIL clamp_step2: got %b pos %0d expected 001 pos 4",
                         {encoder_a_o, encoder_b_o, step_strobe_o}, position_o);
    end
    send_cmd(16'd0, 1'b0);
    tick_n(1);
    n_cmp++;
    if ({encoder_a_o, encoder_b_o, step_strobe_o} !== 3'b011 || position_o !== 16'd5) begin
      n_fail++; $display("FAIL stop_last: got %b pos %0d expected 011 pos 5",
                         {encoder_a_o, encoder_b_o, step_strobe_o}, position_o);
    end
    moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick_n(1);
      if (step_strobe_o || {encoder_a_o, encoder_b_o} != 2'b01 || position_o != 16'd5)
        moved = 1'b1;
    end
    n_cmp++;
    if (moved !== 1'b0) begin
      n_fail++; $display("FAIL stop_idle_moved: got %b expected 0", moved);
    end
    n_cmp++;
    if (cmd_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL stop_ready: got %b expected 1", cmd_ready_o);
    end
  endtask

  task automatic test_enable();
    logic moved;
    send_cmd(16'd10, 1'b0);
    tick_n(10);
    n_cmp++;
    if (step_strobe_o !== 1'b0) begin
      n_fail++; $display("FAIL en_early: got strobe %b expected 0", step_strobe_o);
    end
    tick_n(1);
    n_cmp++;
    if ({encoder_a_o, encoder_b_o, step_strobe_o} !== 3'b111 || position_o !== 16'd6) begin
      n_fail++; $display("FAIL en_first: got %b pos %0d expected 111 pos 6",
                         {encoder_a_o, encoder_b_o, step_strobe_o}, position_o);
    end
    tick_n(4);
    enable_i = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick_n(1);
      if (step_strobe_o || {encoder_a_o, encoder_b_o} != 2'b11 || position_o != 16'd6)
        moved = 1'b1;
    end
    n_cmp++;
    if (moved !== 1'b0) begin
      n_fail++; $display("FAIL en_frozen_moved: got %b expected 0", moved);
    end
    enable_i = 1'b1;
    tick_n(9);
    n_cmp++;
    if ({encoder_a_o, encoder_b_o, step_strobe_o} !== 3'b110) begin
      n_fail++; $display("FAIL en_restart_early: got %b expected 110",
                         {encoder_a_o, encoder_b_o, step_strobe_o});
    end
    tick_n(1);
    n_cmp++;
    if ({encoder_a_o, encoder_b_o, step_strobe_o} !== 3'b101 || position_o !== 16'd7) begin
      n_fail++; $display("FAIL en_restart_step: got %b pos %0d expected 101 pos 7",
                         {encoder_a_o, encoder_b_o, step_strobe_o}, position_o);
    end
  endtask

  task automatic test_glitch();
    logic [1:0] base [3];
    logic [1:0] nxt [3];
    base = '{2'b00, 2'b01, 2'b11};
    nxt  = '{2'b01, 2'b11, 2'b10};
    glitch_en_i = 1'b1;
    send_cmd(16'd8, 1'b0);
    tick_n(9);
    n_cmp++;
    if ({encoder_a_o, encoder_b_o, step_strobe_o} !== 3'b001 || position_o !== 16'd8) begin
      n_fail++; $display("FAIL gl_take: got %b pos %0d expected 001 pos 8",
                         {encoder_a_o, encoder_b_o, step_strobe_o}, position_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick_n(2);
      n_cmp++;
      if (encoder_a_o !== base[i][1]) begin
        n_fail++; $display("FAIL gl_pre%0d: got a %b expected %b", i, encoder_a_o, base[i][1]);
      end
      tick_n(1);
      n_cmp++;
      if ({encoder_a_o, encoder_b_o} !== {~base[i][1], base[i][0]}) begin
        n_fail++; $display("FAIL gl_on%0d: got %b expected %b", i, {encoder_a_o, encoder_b_o},
                           {~base[i][1], base[i][0]});
      end
      tick_n(1);
      n_cmp++;
      if (encoder_a_o !== base[i][1]) begin
        n_fail++; $display("FAIL gl_post%0d: got a %b expected %b", i, encoder_a_o, base[i][1]);
      end
      tick_n(3);
      n_cmp++;
      if (step_strobe_o !== 1'b0) begin
        n_fail++; $display("FAIL gl_gap%0d: got strobe %b expected 0", i, step_strobe_o);
      end
      tick_n(1);
      n_cmp++;
      if ({encoder_a_o, encoder_b_o, step_strobe_o} !== {nxt[i], 1'b1} ||
          position_o !== 16'(9 + i)) begin
        n_fail++; $display("FAIL gl_step%0d: got %b pos %0d expected %b pos %0d", i,
                           {encoder_a_o, encoder_b_o, step_strobe_o}, position_o,
                           {nxt[i], 1'b1}, 9 + i);
      end
    end
    glitch_en_i = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic moved;
    tick_n(2);
    send_cmd(16'd5, 1'b1);
    n_cmp++;
    if (cmd_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_pending: got ready %b expected 0", cmd_ready_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    test_reset();
    #2 rst_ni = 1'b1;
    moved = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick_n(1);
      if (step_strobe_o || encoder_a_o || encoder_b_o || position_o != 16'd0 || !cmd_ready_o)
        moved = 1'b1;
    end
    n_cmp++;
    if (moved !== 1'b0) begin
      n_fail++; $display("FAIL rst_discard_moved: got %b expected 0", moved);
    end
  endtask

  initial begin
    rst_ni       = 1'b0;
    enable_i     = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_period_i = '0;
    cmd_dir_i    = 1'b0;
    glitch_en_i  = 1'b0;
    #12;
    test_reset();
    rst_ni = 1'b1;
    tick_n(2);
    test_forward();
    test_dir_change();
    test_clamp_stop();
    test_enable();
    test_glitch();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
